// File: rtl/assign_bank_if.sv
// Purpose: command/result bundle between the decision controller (master)
//          and the assignment bank (slave).
// Signals:
//   op_valid/op_ready          command handshake
//   op_code, op_idx            command and target variable
//   vimp_p, vimp_n             implied literal for IMPLY
//   randomDigit                decision polarity for DECIDE
//   vout_p, vout_n             per-variable TRUE / FALSE assignment
//   level                      current decision level
//   done, status, back         completion pulse, result code, flip pulse
interface assign_bank_if #(
  parameter int unsigned NUM_VARS = 16,
  parameter int unsigned IDX_W    = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1
);
  logic                op_valid;
  logic                op_ready;
  logic [1:0]          op_code;
  logic [IDX_W-1:0]    op_idx;
  logic                vimp_p;
  logic                vimp_n;
  logic                randomDigit;
  logic [NUM_VARS-1:0] vout_p;
  logic [NUM_VARS-1:0] vout_n;
  logic [IDX_W:0]      level;
  logic                done;
  logic [1:0]          status;
  logic                back;

  modport master (
    output op_valid, op_code, op_idx, vimp_p, vimp_n, randomDigit,
    input  op_ready, vout_p, vout_n, level, done, status, back
  );

  modport slave (
    input  op_valid, op_code, op_idx, vimp_p, vimp_n, randomDigit,
    output op_ready, vout_p, vout_n, level, done, status, back
  );
endinterface

// File: rtl/assign_bank.sv
// Purpose: literal assignment store for NUM_VARS variables with a trail stack
//          supporting decisions, implications and chronological backtracking.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   assign_bank_if.slave: command handshake in, assignment/level/
//         done/status/back out (all outputs registered)
module assign_bank #(
  parameter int unsigned NUM_VARS = 16
) (
  input  logic          clk,
  input  logic          rst,
  assign_bank_if.slave  bus
);

  localparam int unsigned IDX_W = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
  localparam int unsigned LVL_W = IDX_W + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_POP  = 1'b1;

  localparam logic [1:0] OP_DECIDE    = 2'b00;
  localparam logic [1:0] OP_IMPLY     = 2'b01;
  localparam logic [1:0] OP_BACKTRACK = 2'b10;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_ERR   = 2'b01;
  localparam logic [1:0] ST_UNSAT = 2'b10;

  logic [0:0]          r_state, w_state;
  logic [NUM_VARS-1:0] r_vp, r_vn, w_vp, w_vn;
  logic [LVL_W-1:0]    r_sp, w_sp;
  logic [LVL_W-1:0]    r_level, w_level;
  logic                r_done, w_done;
  logic                r_back, w_back;
  logic [1:0]          r_status, w_status;
  logic                r_ready;

  // Trail storage: entry = {idx, is_dec, flipped}
  logic [IDX_W-1:0]    r_tr_idx [NUM_VARS];
  logic [NUM_VARS-1:0] r_tr_dec;
  logic [NUM_VARS-1:0] r_tr_flip;

  logic                w_push;
  logic                w_push_dec;
  logic                w_flip_top;
  logic [IDX_W-1:0]    w_slot;
  logic [IDX_W-1:0]    w_top;
  logic [IDX_W-1:0]    w_top_var;
  logic                w_assigned;
  logic                w_idx_ok;

  // Trail addressing and command qualification
  assign w_slot     = r_sp[IDX_W-1:0];
  assign w_top      = IDX_W'(r_sp - LVL_W'(1));
  assign w_top_var  = r_tr_idx[w_top];
  assign w_idx_ok   = (LVL_W'(bus.op_idx) < LVL_W'(NUM_VARS));
  assign w_assigned = r_vp[bus.op_idx] | r_vn[bus.op_idx];

  // Next-state and datapath update
  always_comb begin
    w_state    = r_state;
    w_vp       = r_vp;
    w_vn       = r_vn;
    w_sp       = r_sp;
    w_level    = r_level;
    w_done     = 1'b0;
    w_back     = 1'b0;
    w_status   = r_status;
    w_push     = 1'b0;
    w_push_dec = 1'b0;
    w_flip_top = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.op_valid) begin
          case (bus.op_code)
            OP_DECIDE: begin
              w_done = 1'b1;
              if (w_assigned || !w_idx_ok) begin
                w_status = ST_ERR;
              end else begin
                w_vp[bus.op_idx] = bus.randomDigit;
                w_vn[bus.op_idx] = ~bus.randomDigit;
                w_push           = 1'b1;
                w_push_dec       = 1'b1;
                w_sp             = r_sp + LVL_W'(1);
                w_level          = r_level + LVL_W'(1);
                w_status         = ST_OK;
              end
            end
            OP_IMPLY: begin
              w_done = 1'b1;
              if (w_assigned || !w_idx_ok || (bus.vimp_p == bus.vimp_n)) begin
                w_status = ST_ERR;
              end else begin
                w_vp[bus.op_idx] = bus.vimp_p;
                w_vn[bus.op_idx] = bus.vimp_n;
                w_push           = 1'b1;
                w_sp             = r_sp + LVL_W'(1);
                w_status         = ST_OK;
              end
            end
            OP_BACKTRACK: begin
              w_state = S_POP;
            end
            default: begin
              // CLEAR: stale trail entries above sp=0 are never read
              w_vp     = '0;
              w_vn     = '0;
              w_sp     = '0;
              w_level  = '0;
              w_done   = 1'b1;
              w_status = ST_OK;
            end
          endcase
        end
      end

      S_POP: begin
        if (r_sp == '0) begin
          w_done   = 1'b1;
          w_status = ST_UNSAT;
          w_state  = S_IDLE;
        end else if (r_tr_dec[w_top] && !r_tr_flip[w_top]) begin
          // Flip the most recent open decision; it stays on the trail as flipped
          w_vp[w_top_var] = r_vn[w_top_var];
          w_vn[w_top_var] = r_vp[w_top_var];
          w_flip_top      = 1'b1;
          w_level         = r_level - LVL_W'(1);
          w_done          = 1'b1;
          w_back          = 1'b1;
          w_status        = ST_OK;
          w_state         = S_IDLE;
        end else begin
          w_vp[w_top_var] = 1'b0;
          w_vn[w_top_var] = 1'b0;
          w_sp            = r_sp - LVL_W'(1);
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_vp     <= '0;
      r_vn     <= '0;
      r_sp     <= '0;
      r_level  <= '0;
      r_done   <= 1'b0;
      r_back   <= 1'b0;
      r_status <= ST_OK;
      r_ready  <= 1'b1;
    end else begin
      r_state  <= w_state;
      r_vp     <= w_vp;
      r_vn     <= w_vn;
      r_sp     <= w_sp;
      r_level  <= w_level;
      r_done   <= w_done;
      r_back   <= w_back;
      r_status <= w_status;
      r_ready  <= (w_state == S_IDLE);
    end
  end

  // Trail writes; contents beyond sp are don't-care so no reset is needed
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_push) begin
        r_tr_idx[w_slot]  <= bus.op_idx;
        r_tr_dec[w_slot]  <= w_push_dec;
        r_tr_flip[w_slot] <= 1'b0;
      end
      if (w_flip_top) begin
        r_tr_flip[w_top] <= 1'b1;
      end
    end
  end

  assign bus.op_ready = r_ready;
  assign bus.vout_p   = r_vp;
  assign bus.vout_n   = r_vn;
  assign bus.level    = r_level;
  assign bus.done     = r_done;
  assign bus.status   = r_status;
  assign bus.back     = r_back;

endmodule

// File: tb/tb_assign_bank.sv
// Purpose: self-checking bench for assign_bank using a reference model that
//          pushes expected results into a scoreboard queue at issue time.
module tb_assign_bank;

  localparam int unsigned NV = 16;

  typedef struct packed {
    logic [1:0]  st;
    logic        bk;
    logic [15:0] p;
    logic [15:0] n;
    logic [4:0]  lv;
    logic [7:0]  lat;
    logic [7:0]  busy;
  } rsp_t;

  typedef struct packed {
    logic [1:0] code;
    logic [3:0] idx;
    logic       vp;
    logic       vn;
    logic       rnd;
  } cmd_t;

  logic clk;
  logic rst;

  assign_bank_if #(.NUM_VARS(NV)) bus ();

  assign_bank #(.NUM_VARS(NV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model state
  logic [15:0] m_p;
  logic [15:0] m_n;
  int          m_lv;
  int          t_idx [$];
  bit          t_dec [$];
  bit          t_flip [$];
  rsp_t        exp_q [$];
  rsp_t        obs;

  function automatic string show(input rsp_t r);
    return $sformatf("st=%0d back=%0d p=%h n=%h lvl=%0d lat=%0d busy=%0d",
                     r.st, r.bk, r.p, r.n, r.lv, r.lat, r.busy);
  endfunction

  task automatic model_reset();
    m_p = '0; m_n = '0; m_lv = 0;
    t_idx.delete(); t_dec.delete(); t_flip.delete();
    exp_q.delete();
  endtask

  // Compute the expected response of one command and enqueue it
  task automatic model_cmd(input cmd_t c);
    rsp_t e;
    int   cleared;
    int   k;
    int   v;
    logic tmp;
    e = '0;
    cleared = 0;
    v = int'(c.idx);
    case (c.code)
      2'b00: begin
        if (m_p[v] | m_n[v]) e.st = 2'd1;
        else begin
          m_p[v] = c.rnd; m_n[v] = !c.rnd;
          t_idx.push_back(v); t_dec.push_back(1'b1); t_flip.push_back(1'b0);
          m_lv++;
        end
      end
      2'b01: begin
        if ((m_p[v] | m_n[v]) || (c.vp == c.vn)) e.st = 2'd1;
        else begin
          m_p[v] = c.vp; m_n[v] = c.vn;
          t_idx.push_back(v); t_dec.push_back(1'b0); t_flip.push_back(1'b0);
        end
      end
      2'b11: begin
        m_p = '0; m_n = '0; m_lv = 0;
        t_idx.delete(); t_dec.delete(); t_flip.delete();
      end
      default: begin
        while (1) begin
          if (t_idx.size() == 0) begin
            e.st = 2'd2;
            break;
          end
          k = t_idx.size() - 1;
          if (t_dec[k] && !t_flip[k]) begin
            tmp = m_p[t_idx[k]];
            m_p[t_idx[k]] = m_n[t_idx[k]];
            m_n[t_idx[k]] = tmp;
            t_flip[k] = 1'b1;
            m_lv--;
            e.bk = 1'b1;
            break;
          end
          m_p[t_idx[k]] = 1'b0;
          m_n[t_idx[k]] = 1'b0;
          void'(t_idx.pop_back()); void'(t_dec.pop_back()); void'(t_flip.pop_back());
          cleared++;
        end
      end
    endcase
    e.p  = m_p;
    e.n  = m_n;
    e.lv = 5'(m_lv);
    // Cycles from acceptance to the cycle showing done; busy = cycles with op_ready low
    e.lat  = (c.code == 2'b10) ? 8'(cleared + 2) : 8'd1;
    e.busy = (c.code == 2'b10) ? 8'(cleared + 1) : 8'd0;
    exp_q.push_back(e);
  endtask

  // Issue one command, wait (bounded) for done and capture the observation
  task automatic send(input cmd_t c);
    int lat;
    int busy;
    model_cmd(c);
    @(negedge clk);
    bus.op_valid    = 1'b1;
    bus.op_code     = c.code;
    bus.op_idx      = c.idx;
    bus.vimp_p      = c.vp;
    bus.vimp_n      = c.vn;
    bus.randomDigit = c.rnd;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    lat  = 1;
    busy = 0;
    while (!bus.done && lat < 40) begin
      if (!bus.op_ready) busy++;
      @(posedge clk);
      #1;
      lat++;
    end
    obs.st   = bus.status;
    obs.bk   = bus.back;
    obs.p    = bus.vout_p;
    obs.n    = bus.vout_n;
    obs.lv   = bus.level;
    obs.lat  = 8'(lat);
    obs.busy = 8'(busy);
  endtask

  task automatic test_reset();
    logic [38:0] got;
    logic [38:0] want;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    got  = {bus.op_ready, bus.vout_p, bus.vout_n, bus.level, bus.done, bus.status, bus.back};
    want = {1'b1, 16'h0000, 16'h0000, 5'd0, 1'b0, 2'b00, 1'b0};
    n_total++;
    if (got !== want) $display("FAIL reset_state: got %h expected %h", got, want);
    else n_pass++;
  endtask

  task automatic test_decide_errors();
    cmd_t seq [4];
    rsp_t e;
    seq[0] = '{code: 2'b00, idx: 4'd3, vp: 1'b0, vn: 1'b0, rnd: 1'b1};
    seq[1] = '{code: 2'b00, idx: 4'd3, vp: 1'b0, vn: 1'b0, rnd: 1'b0};
    seq[2] = '{code: 2'b01, idx: 4'd5, vp: 1'b1, vn: 1'b1, rnd: 1'b0};
    seq[3] = '{code: 2'b01, idx: 4'd5, vp: 1'b0, vn: 1'b0, rnd: 1'b0};
    for (int i = 0; i < 4; i++) begin
      send(seq[i]);
      e = exp_q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL decide_err[%0d]: got %s expected %s", i, show(obs), show(e));
      else n_pass++;
    end
  endtask

  task automatic test_backtrack();
    cmd_t seq [8];
    rsp_t e;
    seq[0] = '{code: 2'b11, idx: 4'd0, vp: 1'b0, vn: 1'b0, rnd: 1'b0};
    seq[1] = '{code: 2'b00, idx: 4'd3, vp: 1'b0, vn: 1'b0, rnd: 1'b1};
    seq[2] = '{code: 2'b01, idx: 4'd5, vp: 1'b1, vn: 1'b0, rnd: 1'b0};
    seq[3] = '{code: 2'b00, idx: 4'd7, vp: 1'b0, vn: 1'b0, rnd: 1'b0};
    seq[4] = '{code: 2'b01, idx: 4'd2, vp: 1'b0, vn: 1'b1, rnd: 1'b0};
    seq[5] = '{code: 2'b10, idx: 4'd0, vp: 1'b0, vn: 1'b0, rnd: 1'b0};
    seq[6] = '{code: 2'b10, idx: 4'd0, vp: 1'b0, vn: 1'b0, rnd: 1'b0};
    seq[7] = '{code: 2'b10, idx: 4'd0, vp: 1'b0, vn: 1'b0, rnd: 1'b0};
    for (int i = 0; i < 8; i++) begin
      send(seq[i]);
      e = exp_q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL backtrack[%0d]: got %s expected %s", i, show(obs), show(e));
      else n_pass++;
    end
  endtask

  task automatic test_fill_unsat();
    cmd_t c;
    rsp_t e;
    for (int i = 0; i <= NV + 1; i++) begin
      if (i == 0) c = '{code: 2'b11, idx: 4'd0, vp: 1'b0, vn: 1'b0, rnd: 1'b0};
      else if (i <= NV) begin
        c.code = 2'b01;
        c.idx  = 4'(i - 1);
        c.vp   = 1'($urandom_range(0, 1));
        c.vn   = !c.vp;
        c.rnd  = 1'b0;
      end else c = '{code: 2'b10, idx: 4'd0, vp: 1'b0, vn: 1'b0, rnd: 1'b0};
      send(c);
      e = exp_q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL fill[%0d]: got %s expected %s", i, show(obs), show(e));
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    cmd_t c;
    rsp_t e;
    int   r;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      c.code = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      c.idx  = 4'($urandom_range(0, NV - 1));
      c.vp   = 1'($urandom_range(0, 1));
      c.vn   = 1'($urandom_range(0, 1));
      c.rnd  = 1'($urandom_range(0, 1));
      send(c);
      e = exp_q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL random[%0d]: got %s expected %s", i, show(obs), show(e));
      else n_pass++;
    end
  endtask

  task automatic test_rst_pop();
    cmd_t c;
    rsp_t e;
    logic [38:0] got;
    logic [38:0] want;
    c = '{code: 2'b11, idx: 4'd0, vp: 1'b0, vn: 1'b0, rnd: 1'b0};
    send(c);
    void'(exp_q.pop_front());
    for (int i = 0; i < 6; i++) begin
      c = '{code: 2'b01, idx: 4'(i + 8), vp: 1'b1, vn: 1'b0, rnd: 1'b0};
      send(c);
      void'(exp_q.pop_front());
    end
    // Leave status at ERR so the reset value is distinguishable
    c = '{code: 2'b01, idx: 4'd1, vp: 1'b1, vn: 1'b1, rnd: 1'b0};
    send(c);
    void'(exp_q.pop_front());
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = 2'b10;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    got  = {bus.op_ready, bus.vout_p, bus.vout_n, bus.level, bus.done, bus.status, bus.back};
    want = {1'b1, 16'h0000, 16'h0000, 5'd0, 1'b0, 2'b00, 1'b0};
    n_total++;
    if (got !== want) $display("FAIL rst_mid_pop: got %h expected %h", got, want);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    c = '{code: 2'b00, idx: 4'd9, vp: 1'b0, vn: 1'b0, rnd: 1'b0};
    send(c);
    e = exp_q.pop_front();
    n_total++;
    if (obs !== e) $display("FAIL after_rst_decide: got %s expected %s", show(obs), show(e));
    else n_pass++;
  endtask

  initial begin
    rst             = 1'b1;
    bus.op_valid    = 1'b0;
    bus.op_code     = 2'b00;
    bus.op_idx      = '0;
    bus.vimp_p      = 1'b0;
    bus.vimp_n      = 1'b0;
    bus.randomDigit = 1'b0;
    model_reset();
    test_reset();
    test_decide_errors();
    test_backtrack();
    test_fill_unsat();
    test_back_to_back();
    test_rst_pop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
